// File: rtl/line_cmd_scheduler.sv
// Two-requester command queue feeding the bresenham line engine.
// Round-robin arbitration, FIFO buffering, engine handshake and watchdog.
module line_cmd_scheduler #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [32:0]      req0_cmd,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [32:0]      req1_cmd,
  output logic             req1_ready,
  output logic [7:0]       eng_x0,
  output logic [7:0]       eng_y0,
  output logic [7:0]       eng_x1,
  output logic [7:0]       eng_y1,
  output logic             eng_start,
  output logic             eng_reset_buff,
  input  logic             eng_done,
  output logic             busy,
  output logic [CNT_W-1:0] lines_drawn,
  output logic             timeout_err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_CLR_SET,
    S_CLR_EXIT,
    S_GAP
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [32:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_rr;
  logic [TW-1:0]     r_tcnt;
  logic              r_start;
  logic              r_rb;
  logic [7:0]        r_x0, r_y0, r_x1, r_y1;
  logic [CNT_W-1:0]  r_lines;
  logic              r_terr;

  logic              w_not_full;
  logic              w_empty;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_push;
  logic              w_pop;
  logic [32:0]       w_push_cmd;
  logic [32:0]       w_head;
  logic              w_to;

  assign w_not_full = (r_count < CW'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_gnt0     = w_not_full && req0_valid && (!req1_valid || !r_rr);
  assign w_gnt1     = w_not_full && req1_valid && (!req0_valid || r_rr);
  assign w_push     = w_gnt0 || w_gnt1;
  assign w_pop      = (r_state == S_LOAD);
  assign w_push_cmd = w_gnt0 ? req0_cmd : req1_cmd;
  assign w_head     = r_mem[r_rptr];
  assign w_to       = (r_state == S_WAIT) && !eng_done &&
                      (r_tcnt == TW'(TIMEOUT_CYC - 1));

  assign req0_ready     = w_gnt0;
  assign req1_ready     = w_gnt1;
  assign eng_x0         = r_x0;
  assign eng_y0         = r_y0;
  assign eng_x1         = r_x1;
  assign eng_y1         = r_y1;
  assign eng_start      = r_start;
  assign eng_reset_buff = r_rb;
  assign lines_drawn    = r_lines;
  assign timeout_err    = r_terr;
  assign busy           = (r_state != S_IDLE) || !w_empty;

  // Queue storage; contents need no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_push_cmd;
  end

  // Queue pointers, occupancy and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_rr    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
        r_rr   <= w_gnt0;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // Sequencer next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:     if (!w_empty) w_next = S_LOAD;
      S_LOAD:     w_next = w_head[32] ? S_CLR_SET : S_ISSUE;
      S_ISSUE:    w_next = S_WAIT;
      S_WAIT:     if (eng_done || w_to) w_next = S_GAP;
      S_CLR_SET:  w_next = S_CLR_EXIT;
      S_CLR_EXIT: w_next = S_GAP;
      S_GAP:      w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // State register plus registered engine strobes decoded from next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_start <= 1'b0;
      r_rb    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_start <= (w_next == S_ISSUE) || (w_next == S_CLR_EXIT);
      r_rb    <= (w_next == S_CLR_SET);
    end
  end

  // Endpoints load on entry to LOAD so they are valid before start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x0 <= '0;
      r_y0 <= '0;
      r_x1 <= '0;
      r_y1 <= '0;
    end else if (r_state == S_IDLE && !w_empty) begin
      r_x0 <= w_head[31:24];
      r_y0 <= w_head[23:16];
      r_x1 <= w_head[15:8];
      r_y1 <= w_head[7:0];
    end
  end

  // Watchdog, completion counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt  <= '0;
      r_lines <= '0;
      r_terr  <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)     r_tcnt <= '0;
      else if (r_state == S_WAIT) r_tcnt <= r_tcnt + 1'b1;
      if (r_state == S_WAIT && eng_done) r_lines <= r_lines + 1'b1;
      if (w_to) r_terr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_line_cmd_scheduler.sv
// Directed bench for line_cmd_scheduler with a behavioural line engine.
// Vector table covers arbitration; hand sequences cover timing corners.
module tb_line_cmd_scheduler;

  localparam int DEPTH = 4;
  localparam int TO    = 1024;
  localparam int CW    = 16;

  logic          clk;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic [32:0]   req0_cmd, req1_cmd;
  logic          req0_ready, req1_ready;
  logic [7:0]    eng_x0, eng_y0, eng_x1, eng_y1;
  logic          eng_start, eng_reset_buff, eng_done;
  logic          busy;
  logic [CW-1:0] lines_drawn;
  logic          timeout_err;

  line_cmd_scheduler #(
    .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_ready(req1_ready),
    .eng_x0(eng_x0), .eng_y0(eng_y0), .eng_x1(eng_x1), .eng_y1(eng_y1),
    .eng_start(eng_start), .eng_reset_buff(eng_reset_buff),
    .eng_done(eng_done), .busy(busy), .lines_drawn(lines_drawn),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Engine model: done arrives lat negedges after a draw start (0 = never).
  int         lat = 12;
  int         ecnt = 0;
  int         n_starts = 0;
  int         n_both = 0;
  bit         prev_rb = 0;
  logic [7:0] log_q[$];

  initial eng_done = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      ecnt = 0;
      eng_done = 1'b0;
      prev_rb = 0;
    end else begin
      eng_done = 1'b0;
      if (eng_start && eng_reset_buff) n_both++;
      if (eng_start) begin
        n_starts++;
        if (!prev_rb) begin
          log_q.push_back(eng_x0);
          ecnt = lat;
        end
      end else if (ecnt != 0) begin
        ecnt--;
        if (ecnt == 0) eng_done = 1'b1;
      end
      prev_rb = eng_reset_buff;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for(input int which, input int budget, input string nm);
    bit hit;
    hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      case (which)
        0: hit = eng_start;
        1: hit = eng_done;
        2: hit = eng_reset_buff;
        default: hit = !busy;
      endcase
      if (!hit) step();
    end
    chk({nm, "_reached"}, hit, 1);
  endtask

  function automatic logic [32:0] mk(input bit clr, input logic [7:0] x0,
                                     input logic [7:0] y0, input logic [7:0] x1,
                                     input logic [7:0] y1);
    return {clr, x0, y0, x1, y1};
  endfunction

  typedef struct {
    logic       v0;
    logic       v1;
    logic [7:0] id0;
    logic [7:0] id1;
    logic       er0;
    logic       er1;
  } vec_t;

  vec_t tbl[7];
  int   exp_q[$];
  int   acc;
  int   base_starts;

  initial begin
    tbl[0] = '{1, 1, 8'd1, 8'd2, 1, 0};
    tbl[1] = '{1, 1, 8'd3, 8'd2, 0, 1};
    tbl[2] = '{0, 1, 8'd3, 8'd4, 0, 1};
    tbl[3] = '{1, 0, 8'd3, 8'd0, 1, 0};
    tbl[4] = '{0, 0, 8'd0, 8'd0, 0, 0};
    tbl[5] = '{1, 1, 8'd5, 8'd6, 0, 1};
    tbl[6] = '{1, 1, 8'd5, 8'd7, 0, 0};

    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_cmd = '0;
    req1_cmd = '0;
    step();
    step();

    chk("rst_x0", eng_x0, 0);
    chk("rst_y1", eng_y1, 0);
    chk("rst_start", eng_start, 0);
    chk("rst_rb", eng_reset_buff, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lines", lines_drawn, 0);
    chk("rst_terr", timeout_err, 0);
    rst = 1'b0;
    step();

    // Round-robin arbitration and full-queue backpressure.
    lat = 12;
    log_q.delete();
    for (int i = 0; i < 7; i++) begin
      req0_valid = tbl[i].v0;
      req1_valid = tbl[i].v1;
      req0_cmd = mk(0, tbl[i].id0, 8'd0, 8'd9, 8'd9);
      req1_cmd = mk(0, tbl[i].id1, 8'd0, 8'd9, 8'd9);
      #1;
      chk($sformatf("rr_ready0_row%0d", i), req0_ready, tbl[i].er0);
      chk($sformatf("rr_ready1_row%0d", i), req1_ready, tbl[i].er1);
      if (tbl[i].er0) exp_q.push_back(tbl[i].id0);
      if (tbl[i].er1) exp_q.push_back(tbl[i].id1);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_for(3, 300, "rr_drain");
    chk("rr_order_len", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < log_q.size())
        chk($sformatf("rr_order_%0d", i), log_q[i], exp_q[i]);
    chk("rr_lines", lines_drawn, 5);
    chk("rr_terr", timeout_err, 0);

    // Single draw with exact handshake timing.
    lat = 20;
    base_starts = n_starts;
    req0_valid = 1'b1;
    req0_cmd = mk(0, 8'd0, 8'd0, 8'd3, 8'd3);
    #1;
    chk("s_ready", req0_ready, 1);
    step();
    req0_valid = 1'b0;
    #1;
    chk("s_ready_drop", req0_ready, 0);
    chk("s_idle_start", eng_start, 0);
    step();
    chk("s_load_x1", eng_x1, 3);
    chk("s_load_y1", eng_y1, 3);
    chk("s_load_start", eng_start, 0);
    step();
    chk("s_issue_start", eng_start, 1);
    step();
    chk("s_wait_start", eng_start, 0);
    wait_for(1, 40, "s_done");
    chk("s_lines", lines_drawn, 6);
    chk("s_gap_busy", busy, 1);
    step();
    chk("s_idle_busy", busy, 0);
    chk("s_one_start", n_starts - base_starts, 1);

    // Clear command: reset_buff pulse, then start, then gap.
    req1_valid = 1'b1;
    req1_cmd = mk(1, 8'd77, 8'd1, 8'd2, 8'd3);
    #1;
    chk("c_ready", req1_ready, 1);
    step();
    req1_valid = 1'b0;
    step();
    chk("c_load_rb", eng_reset_buff, 0);
    step();
    chk("c_set_rb", eng_reset_buff, 1);
    chk("c_set_start", eng_start, 0);
    step();
    chk("c_exit_start", eng_start, 1);
    chk("c_exit_rb", eng_reset_buff, 0);
    step();
    chk("c_gap_start", eng_start, 0);
    chk("c_gap_busy", busy, 1);
    step();
    chk("c_idle_busy", busy, 0);
    chk("c_lines", lines_drawn, 6);

    // Backpressure: engine stalls, queue fills behind the active draw.
    lat = 300;
    acc = 0;
    req0_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      req0_cmd = mk(0, 8'(20 + acc), 8'd0, 8'd1, 8'd1);
      #1;
      if (req0_ready) acc++;
      step();
    end
    chk("bp_accepted", acc, DEPTH + 1);
    chk("bp_full_ready", req0_ready, 0);
    wait_for(1, 400, "bp_done");
    chk("bp_gap_ready", req0_ready, 0);
    step();
    step();
    chk("bp_load_ready", req0_ready, 0);
    step();
    chk("bp_issue_ready", req0_ready, 1);
    step();
    req0_valid = 1'b0;
    wait_for(3, 2500, "bp_drain");
    chk("bp_lines", lines_drawn, 12);

    // Watchdog: engine never answers.
    lat = 0;
    req0_valid = 1'b1;
    req0_cmd = mk(0, 8'd40, 8'd0, 8'd1, 8'd1);
    step();
    req0_cmd = mk(0, 8'd41, 8'd0, 8'd1, 8'd1);
    step();
    req0_cmd = mk(0, 8'd42, 8'd0, 8'd1, 8'd1);
    step();
    req0_valid = 1'b0;
    wait_for(0, 10, "to_issue");
    chk("to_x0_first", eng_x0, 40);
    for (int i = 0; i < TO; i++) step();
    chk("to_err_before", timeout_err, 0);
    step();
    chk("to_err_set", timeout_err, 1);
    wait_for(0, 10, "to_issue2");
    chk("to_x0_second", eng_x0, 41);
    chk("to_err_sticky", timeout_err, 1);
    chk("to_lines", lines_drawn, 12);

    // Asynchronous reset in the middle of a wait.
    for (int i = 0; i < 5; i++) step();
    #2;
    rst = 1'b1;
    #1;
    chk("ar_x0", eng_x0, 0);
    chk("ar_start", eng_start, 0);
    chk("ar_lines", lines_drawn, 0);
    chk("ar_terr", timeout_err, 0);
    chk("ar_busy", busy, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("ar_fifo_empty", busy, 0);
    chk("ar_no_start", eng_start, 0);

    chk("never_both", n_both, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
